riscv_lsu: RTL and testbench

//  Load/store unit between riscv_core's memory port and data memory.

---
 rtl/riscv_lsu_pkg.sv | 26 ++
 rtl/riscv_lsu_align.sv | 39 +++
 rtl/riscv_lsu.sv | 115 +++++++++++
 tb/tb_riscv_lsu.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 size codes,
// FSM state type and the misalignment rule used by riscv_lsu.
package riscv_lsu_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } lsu_state_t;

    // Unused size codes behave as words, so they share the word alignment rule.
    function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] off);
        case (size)
            LDST_B, LDST_BU: return 1'b0;
            LDST_H, LDST_HU: return off[0];
            default:         return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational lane logic: byte enables and store replication from size/offset,
// plus load byte/half extraction with sign or zero extension.
module riscv_lsu_align
    import riscv_lsu_pkg::*;
(
    input  logic [2:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wd_i,
    input  logic [31:0] rd_i,
    output logic [3:0]  be_o,
    output logic [31:0] wd_o,
    output logic [31:0] rd_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rd_i[{off_i, 3'b000} +: 8];
        half_sel = rd_i[{off_i[1], 4'b0000} +: 16];
        be_o     = 4'b1111;
        wd_o     = wd_i;
        rd_o     = rd_i;
        case (size_i)
            LDST_B, LDST_BU: begin
                be_o = 4'b0001 << off_i;
                wd_o = {4{wd_i[7:0]}};
                rd_o = (size_i == LDST_B) ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
            end
            LDST_H, LDST_HU: begin
                be_o = off_i[1] ? 4'b1100 : 4'b0011;
                wd_o = {2{wd_i[15:0]}};
                rd_o = (size_i == LDST_H) ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// RV32I load/store unit: IDLE->BUSY->DONE handshake FSM with core stall generation.
// Optional LSU_MISALIGN_EXC_EN adds core_misalign_o and skips memory for misaligned H/W.
module riscv_lsu
    import riscv_lsu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
`ifdef LSU_MISALIGN_EXC_EN
    output logic        core_misalign_o,
`endif
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    lsu_state_t  state_q, state_d;
    logic [31:0] addr_q;
    logic [2:0]  size_q;
    logic        we_q;
    logic [31:0] wd_q;
    logic [31:0] rd_q;
    logic        stall_d;
    logic        misalign_d;
    logic [3:0]  be_w;
    logic [31:0] wd_rep_w;
    logic [31:0] ld_data_w;

`ifdef LSU_MISALIGN_EXC_EN
    logic misalign_q;
    assign misalign_d      = is_misaligned(core_size_i, core_addr_i[1:0]);
    assign core_misalign_o = (state_q == DONE) && misalign_q;
`else
    assign misalign_d = 1'b0;
`endif

    riscv_lsu_align u_align (
        .size_i (size_q),
        .off_i  (addr_q[1:0]),
        .wd_i   (wd_q),
        .rd_i   (mem_rd_i),
        .be_o   (be_w),
        .wd_o   (wd_rep_w),
        .rd_o   (ld_data_w)
    );

    always_comb begin
        state_d = state_q;
        stall_d = 1'b0;
        case (state_q)
            IDLE: begin
                stall_d = core_req_i;
                if (core_req_i) begin
                    state_d = misalign_d ? DONE : BUSY;
                end
            end
            BUSY: begin
                stall_d = 1'b1;
                if (mem_ready_i) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            wd_q    <= '0;
            rd_q    <= '0;
`ifdef LSU_MISALIGN_EXC_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            // The registered request is the only copy the memory side ever sees.
            if (state_q == IDLE && core_req_i) begin
                addr_q <= core_addr_i;
                size_q <= core_size_i;
                we_q   <= core_we_i;
                wd_q   <= core_wd_i;
`ifdef LSU_MISALIGN_EXC_EN
                misalign_q <= misalign_d;
`endif
            end
            if (state_q == BUSY && mem_ready_i && !we_q) begin
                rd_q <= ld_data_w;
            end
        end
    end

    assign core_rd_o    = rd_q;
    assign core_stall_o = stall_d && !rst_i;
    assign mem_req_o    = (state_q == BUSY);
    assign mem_we_o     = (state_q == BUSY) && we_q;
    assign mem_be_o     = (state_q == BUSY) ? be_w : 4'b0000;
    assign mem_addr_o   = {addr_q[31:2], 2'b00};
    assign mem_wd_o     = wd_rep_w;

endmodule

// File: tb/tb_riscv_lsu.sv
// Randomized self-checking bench for riscv_lsu against a transaction-level model.
module tb_riscv_lsu;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        core_req_i, core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i, core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wd_o, mem_rd_i;
    logic        mem_ready_i;
    logic        misalign;

    int checks = 0;
    int errors = 0;
    int ntxn   = 0;

    logic        chk_en = 1'b0;
    logic        pinned = 1'b0;
    logic        exp_stall, exp_req, exp_full, exp_we, exp_mis;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr, exp_wd, exp_rd;
    logic [31:0] model_rd;

    always #5 clk = ~clk;

    riscv_lsu dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_size_i  (core_size_i),
        .core_addr_i  (core_addr_i),
        .core_wd_i    (core_wd_i),
        .core_rd_o    (core_rd_o),
        .core_stall_o (core_stall_o),
`ifdef LSU_MISALIGN_EXC_EN
        .core_misalign_o (misalign),
`endif
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wd_o     (mem_wd_o),
        .mem_rd_i     (mem_rd_i),
        .mem_ready_i  (mem_ready_i)
    );

`ifndef LSU_MISALIGN_EXC_EN
    assign misalign = 1'b0;
`endif

    // ---------------- behavioural model ----------------
    function automatic int kind(input logic [2:0] size);
        // 0 byte signed, 1 byte unsigned, 2 half signed, 3 half unsigned, 4 word
        case (size)
            3'd0:    return 0;
            3'd4:    return 1;
            3'd1:    return 2;
            3'd5:    return 3;
            default: return 4;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] size, input logic [31:0] addr);
        int k = kind(size);
        if (k <= 1) return 4'(1 << (addr % 4));
        if (k <= 3) return ((addr / 2) % 2 == 1) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] size, input logic [31:0] wd);
        int k = kind(size);
        if (k <= 1) return (wd & 32'hFF) * 32'h01010101;
        if (k <= 3) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] m_ld(input logic [2:0] size, input logic [31:0] addr,
                                         input logic [31:0] word);
        int k = kind(size);
        logic [31:0] b, h;
        b = (word >> (8 * (addr % 4))) & 32'hFF;
        h = (word >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
        case (k)
            0:       return (b >= 128) ? (b | 32'hFFFFFF00) : b;
            1:       return b;
            2:       return (h >= 32768) ? (h | 32'hFFFF0000) : h;
            3:       return h;
            default: return word;
        endcase
    endfunction

    function automatic logic m_mis(input logic [2:0] size, input logic [31:0] addr);
`ifdef LSU_MISALIGN_EXC_EN
        int k = kind(size);
        if (k <= 1) return 1'b0;
        if (k <= 3) return (addr % 2) != 0;
        return (addr % 4) != 0;
`else
        return 1'b0 & size[0] & addr[0];
`endif
    endfunction

    // ---------------- compare process ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!pinned) begin
            pinned = 1'b1;
            chk("pin_lb",   m_ld(3'd0, 32'h2, 32'h80FF7F01), 32'hFFFFFFFF);
            chk("pin_lbu",  m_ld(3'd4, 32'h3, 32'h80FF7F01), 32'h00000080);
            chk("pin_lh",   m_ld(3'd1, 32'h2, 32'h80FF7F01), 32'hFFFF80FF);
            chk("pin_lhu",  m_ld(3'd5, 32'h0, 32'h80FF7F01), 32'h00007F01);
            chk("pin_sb_be", 32'(m_be(3'd0, 32'h13)), 32'h8);
            chk("pin_sb_wd", m_wd(3'd0, 32'hA5), 32'hA5A5A5A5);
        end
        if (chk_en) begin
            chk("stall",    32'(core_stall_o), 32'(exp_stall));
            chk("mem_req",  32'(mem_req_o),    32'(exp_req));
            chk("core_rd",  core_rd_o,         exp_rd);
            chk("misalign", 32'(misalign),     32'(exp_mis));
            if (exp_full) begin
                chk("mem_we",   32'(mem_we_o), 32'(exp_we));
                chk("mem_be",   32'(mem_be_o), 32'(exp_be));
                chk("mem_addr", mem_addr_o,    exp_addr);
                chk("mem_wd",   mem_wd_o,      exp_wd);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_core();
        core_req_i  = 1'($urandom);
        core_we_i   = 1'($urandom);
        core_size_i = 3'($urandom);
        core_addr_i = $urandom;
        core_wd_i   = $urandom;
    endtask

    task automatic do_txn(input logic we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] word,
                          input int waits, input int rst_at);
        logic mis;
        logic aborted;
        mis     = m_mis(size, addr);
        aborted = 1'b0;
        step();
        core_req_i = 1'b1; core_we_i = we; core_size_i = size;
        core_addr_i = addr; core_wd_i = wd;
        mem_ready_i = 1'b0; mem_rd_i = $urandom;
        chk_en = 1'b1; exp_stall = 1'b1; exp_req = 1'b0; exp_full = 1'b0;
        exp_mis = 1'b0; exp_rd = model_rd;
        if (mis) begin
            step();
            scramble_core();
            exp_stall = 1'b0; exp_mis = 1'b1; exp_rd = model_rd;
        end else begin
            for (int k = 0; k <= waits && !aborted; k++) begin
                step();
                scramble_core();
                mem_ready_i = (k == waits);
                mem_rd_i    = (k == waits) ? word : $urandom;
                exp_stall = 1'b1; exp_req = 1'b1; exp_full = 1'b1; exp_we = we;
                exp_be = m_be(size, addr); exp_addr = addr & 32'hFFFFFFFC;
                exp_wd = m_wd(size, wd);
                if (k == rst_at) begin
                    rst_i = 1'b1; mem_ready_i = 1'b0; exp_stall = 1'b0;
                    step();
                    rst_i = 1'b0; core_req_i = 1'b0;
                    model_rd = 32'h0;
                    exp_stall = 1'b0; exp_req = 1'b0; exp_full = 1'b1; exp_we = 1'b0;
                    exp_be = 4'h0; exp_addr = 32'h0; exp_wd = 32'h0; exp_rd = 32'h0;
                    aborted = 1'b1;
                end
            end
            if (!aborted) begin
                if (!we) model_rd = m_ld(size, addr, word);
                step();
                scramble_core();
                mem_ready_i = 1'b0;
                exp_stall = 1'b0; exp_req = 1'b0; exp_full = 1'b0; exp_rd = model_rd;
            end
        end
        // A request seen in DONE must not start a new access.
        step();
        core_req_i = 1'b0; mem_ready_i = 1'($urandom);
        exp_stall = 1'b0; exp_req = 1'b0; exp_full = 1'b0; exp_mis = 1'b0; exp_rd = model_rd;
        ntxn++;
        $display("txn %0d we=%0d size=%0d addr=0x%08h wd=0x%08h word=0x%08h waits=%0d rst_at=%0d rd=0x%08h",
                 ntxn, we, size, addr, wd, word, waits, rst_at, model_rd);
    endtask

    initial begin
        logic [2:0] sz;
        rst_i = 1'b1; core_req_i = 1'b1; core_we_i = 1'b1; core_size_i = 3'd2;
        core_addr_i = 32'h1234; core_wd_i = 32'hFFFFFFFF;
        mem_rd_i = 32'h0; mem_ready_i = 1'b1; model_rd = 32'h0;
        step();
        step();
        chk_en = 1'b1; exp_stall = 1'b0; exp_req = 1'b0; exp_full = 1'b1; exp_we = 1'b0;
        exp_be = 4'h0; exp_addr = 32'h0; exp_wd = 32'h0; exp_rd = 32'h0; exp_mis = 1'b0;
        step();
        rst_i = 1'b0; core_req_i = 1'b0; mem_ready_i = 1'b0;
        exp_full = 1'b0;

        do_txn(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 0, -1);
        do_txn(1'b1, 3'd0, 32'h13, 32'h000000A5, 32'h0, 0, -1);
        do_txn(1'b0, 3'd0, 32'h02, 32'h0, 32'h80FF7F01, 0, -1);
        do_txn(1'b0, 3'd4, 32'h03, 32'h0, 32'h80FF7F01, 1, -1);
        do_txn(1'b0, 3'd1, 32'h02, 32'h0, 32'h80FF7F01, 0, -1);
        do_txn(1'b0, 3'd5, 32'h00, 32'h0, 32'h80FF7F01, 2, -1);
        do_txn(1'b0, 3'd2, 32'h20, 32'h0, 32'hCAFEF00D, 3, -1);
        do_txn(1'b0, 3'd2, 32'h24, 32'h0, 32'h11223344, 3, 1);
        do_txn(1'b0, 3'd2, 32'h06, 32'h0, 32'h55667788, 0, -1);
        do_txn(1'b1, 3'd1, 32'h1E, 32'h0000BEEF, 32'h0, 1, -1);

        for (int i = 0; i < 300; i++) begin
            sz = 3'($urandom);
            do_txn(1'($urandom), sz, $urandom, $urandom, $urandom,
                   int'($urandom_range(0, 3)), ($urandom_range(0, 19) == 0) ? 0 : -1);
        end

        step();
        chk_en = 1'b0;
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
